// File: rtl/interlace_fetch_scheduler.sv
// Interlaced frame-buffer line fetch scheduler: one memory read request per output
// line tick, alternating field parity, with underrun detection on dropped ticks.
module interlace_fetch_scheduler #(
  parameter  int V_ACTIVE    = 1080,
  parameter  int LINE_STRIDE = 2048,
  parameter  int BASE_ADDR   = 0,
  parameter  int ADDR_W      = 24,
  localparam int LINES       = V_ACTIVE / 2,
  localparam int IDX_W       = $clog2(LINES) + 1
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              field_start,
  input  logic              line_tick,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic              rd_done,
  output logic              field_o,
  output logic [IDX_W-1:0]  line_idx_o,
  output logic              busy,
  output logic              underrun,
  output logic [7:0]        underrun_cnt
);

  // state     | meaning
  // IDLE      | disabled or no field started yet; ticks ignored
  // WAIT_TICK | field active, waiting for the next line tick
  // REQ       | rd_req asserted, waiting for rd_ack
  // FETCH     | request accepted, waiting for rd_done
  typedef enum logic [1:0] {IDLE, WAIT_TICK, REQ, FETCH} state_t;

  state_t state, state_nxt;

  logic             first_field;
  logic             stale;
  logic             field_q;
  logic [IDX_W-1:0] line_idx;
  logic             fs_en;
  logic             in_flight;
  logic             field_eff;
  logic [IDX_W-1:0] idx_eff;
  logic [ADDR_W-1:0] line_num;
  logic [ADDR_W-1:0] addr_calc;

  assign fs_en     = field_start & enable;
  assign in_flight = (state == REQ) || (state == FETCH);

  // A field start in the same cycle as a tick must address line 0 of the new field.
  always_comb begin
    field_eff = field_q;
    idx_eff   = line_idx;
    if (fs_en) begin
      field_eff = (state == IDLE || first_field) ? 1'b0 : ~field_q;
      idx_eff   = '0;
    end
  end

  assign line_num  = ADDR_W'({idx_eff, field_eff});
  assign addr_calc = ADDR_W'(BASE_ADDR) + line_num * ADDR_W'(LINE_STRIDE);

  always_ff @(posedge sys_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (fs_en) state_nxt = line_tick ? REQ : WAIT_TICK;
      end
      WAIT_TICK: begin
        if (!enable)
          state_nxt = IDLE;
        else if (line_tick && (idx_eff < IDX_W'(LINES)))
          state_nxt = REQ;
      end
      REQ: begin
        if (rd_ack) state_nxt = FETCH;
      end
      FETCH: begin
        if (rd_done) state_nxt = enable ? WAIT_TICK : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_req = (state == REQ);
    busy   = in_flight;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rd_addr      <= '0;
      field_q      <= 1'b0;
      line_idx     <= '0;
      first_field  <= 1'b1;
      stale        <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= 8'd0;
    end else begin
      underrun <= line_tick & in_flight;
      if (line_tick && in_flight && (underrun_cnt != 8'hFF))
        underrun_cnt <= underrun_cnt + 8'd1;

      if (fs_en) begin
        field_q     <= field_eff;
        line_idx    <= '0;
        first_field <= 1'b0;
        // The line in flight belongs to the old field; if it completes this very
        // cycle there is nothing left to discount.
        if (in_flight)
          stale <= ~((state == FETCH) && rd_done);
      end else if ((state == FETCH) && rd_done) begin
        if (stale) stale    <= 1'b0;
        else       line_idx <= line_idx + IDX_W'(1);
      end

      if ((state_nxt == REQ) && (state != REQ))
        rd_addr <= addr_calc;
    end
  end

  assign field_o    = field_q;
  assign line_idx_o = line_idx;

endmodule

// File: tb/tb_interlace_fetch_scheduler.sv
// Bench for interlace_fetch_scheduler: directed scenarios plus a random phase, every
// cycle compared against a transaction-level model of the scheduler.
module tb_interlace_fetch_scheduler;

  localparam int V_ACTIVE = 8;
  localparam int STRIDE   = 16;
  localparam int BASE     = 'h100;
  localparam int ADDR_W   = 24;
  localparam int LINES    = V_ACTIVE / 2;
  localparam int IDX_W    = $clog2(LINES) + 1;

  logic              sys_clk = 0;
  logic              rst = 1, enable = 0, field_start = 0, line_tick = 0;
  logic              rd_ack = 0, rd_done = 0;
  logic              rd_req, field_o, busy, underrun;
  logic [ADDR_W-1:0] rd_addr;
  logic [IDX_W-1:0]  line_idx_o;
  logic [7:0]        underrun_cnt;

  interlace_fetch_scheduler #(
    .V_ACTIVE(V_ACTIVE), .LINE_STRIDE(STRIDE), .BASE_ADDR(BASE), .ADDR_W(ADDR_W)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .enable(enable), .field_start(field_start),
    .line_tick(line_tick), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_done(rd_done), .field_o(field_o), .line_idx_o(line_idx_o), .busy(busy),
    .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int n_pass = 0, n_total = 0;

  // Model: m_on = a field is running, m_req = request outstanding, m_fetch = data pending.
  bit m_on, m_req, m_fetch, m_field, m_stale, m_und;
  int m_idx, m_cnt, m_addr;
  int ack_lat = 2, done_lat = 5, ack_dly, done_dly;
  int issued[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_on = 0; m_req = 0; m_fetch = 0; m_field = 0; m_stale = 0; m_und = 0;
    m_idx = 0; m_cnt = 0; m_addr = 0;
  endtask

  task automatic issue();
    m_req   = 1;
    m_addr  = (BASE + (2 * m_idx + int'(m_field)) * STRIDE) & ((1 << ADDR_W) - 1);
    ack_dly = ack_lat;
    issued.push_back(m_addr);
  endtask

  task automatic model_step();
    bit was_busy, fs, done_now;
    was_busy = m_req | m_fetch;
    fs       = field_start & enable;
    done_now = m_fetch & rd_done;
    if (rst) begin
      model_reset();
      return;
    end
    m_und = line_tick & was_busy;
    if (m_und && m_cnt < 255) m_cnt++;
    if (!m_on) begin
      if (fs) begin
        m_on = 1; m_field = 0; m_idx = 0;
        if (line_tick) issue();
      end
    end else if (!was_busy) begin
      if (!enable) m_on = 0;
      else begin
        if (fs) begin m_field = !m_field; m_idx = 0; end
        if (line_tick && m_idx < LINES) issue();
      end
    end else begin
      if (fs) begin
        m_field = !m_field; m_idx = 0; m_stale = !done_now;
      end else if (done_now) begin
        if (m_stale) m_stale = 0;
        else m_idx++;
      end
      if (m_req && rd_ack) begin
        m_req = 0; m_fetch = 1; done_dly = done_lat;
      end else if (done_now) begin
        m_fetch = 0;
        if (!enable) m_on = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("rd_req", rd_req, m_req);
    chk("rd_addr", rd_addr, m_addr);
    chk("busy", busy, m_req | m_fetch);
    chk("field_o", field_o, m_field);
    chk("line_idx_o", line_idx_o, m_idx);
    chk("underrun", underrun, m_und);
    chk("underrun_cnt", underrun_cnt, m_cnt);
  endtask

  // One clock: model follows the inputs seen at the edge, then the memory responder
  // prepares ack/done for the next edge.
  task automatic cycle();
    @(posedge sys_clk);
    model_step();
    #1;
    check_all();
    rd_ack = 0; rd_done = 0;
    if (m_req) begin if (ack_dly == 0) rd_ack = 1; else ack_dly--; end
    if (m_fetch) begin if (done_dly == 0) rd_done = 1; else done_dly--; end
  endtask

  task automatic pulse(input bit fs, input bit tk);
    field_start = fs; line_tick = tk;
    cycle();
    field_start = 0; line_tick = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_req || m_fetch) && n < 100) begin cycle(); n++; end
    chk("wait_idle_bound", n < 100, 1);
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (!m_fetch && n < 100) begin cycle(); n++; end
    chk("wait_fetch_bound", n < 100, 1);
  endtask

  task automatic run_field(input int first_addr, input int fld);
    issued.delete();
    pulse(1, 0);
    cycle();
    for (int i = 0; i < LINES; i++) begin
      pulse(0, 1);
      wait_idle();
      cycle();
    end
    chk("field_req_count", issued.size(), LINES);
    for (int i = 0; i < LINES && i < issued.size(); i++)
      chk("field_addr", issued[i], first_addr + i * 2 * STRIDE);
    chk("field_parity", field_o, fld);
    chk("field_end_idx", line_idx_o, LINES);
  endtask

  initial begin
    model_reset();
    cycle(); cycle();
    chk("reset_req", rd_req, 0);
    chk("reset_addr", rd_addr, 0);
    chk("reset_cnt", underrun_cnt, 0);
    rst = 0;
    cycle();

    // Nominal first field, then an ignored fifth tick
    enable = 1;
    run_field('h100, 0);
    pulse(0, 1);
    cycle();
    chk("extra_tick_no_req", busy, 0);
    chk("extra_tick_no_underrun", underrun_cnt, 0);

    // Second field: bottom parity
    run_field('h110, 1);

    // Underrun: tick dropped while fetching
    pulse(1, 0);
    issued.delete();
    pulse(0, 1);
    wait_fetch();
    pulse(0, 1);
    chk("underrun_pulse", underrun, 1);
    chk("underrun_cnt_1", underrun_cnt, 1);
    cycle();
    chk("underrun_one_cycle", underrun, 0);
    wait_idle();
    cycle();
    chk("underrun_single_req", issued.size(), 1);
    chk("underrun_idx_plus1", line_idx_o, 1);
    for (int i = 0; i < 300; i++) begin
      ack_lat = $urandom_range(1, 3);
      if (m_idx >= LINES) begin pulse(1, 0); cycle(); end
      pulse(0, 1);
      if ($urandom_range(0, 1) == 0) wait_fetch();
      pulse(0, 1);
      wait_idle();
      cycle();
    end
    chk("underrun_saturated", underrun_cnt, 255);
    ack_lat = 2;

    // Stale: field start while line 2 of field 0 is fetching
    enable = 0;
    wait_idle();
    cycle(); cycle();
    enable = 1;
    pulse(1, 0);
    for (int i = 0; i < 2; i++) begin pulse(0, 1); wait_idle(); cycle(); end
    pulse(0, 1);
    wait_fetch();
    pulse(1, 0);
    wait_idle();
    cycle();
    chk("stale_field", field_o, 1);
    chk("stale_idx", line_idx_o, 0);
    issued.delete();
    pulse(0, 1);
    chk("stale_next_addr", rd_addr, 'h110);
    wait_idle();
    cycle();

    // Field start and tick together in WAIT_TICK
    pulse(1, 1);
    chk("simul_req", rd_req, 1);
    chk("simul_addr", rd_addr, 'h100);
    chk("simul_field", field_o, 0);
    wait_idle();
    cycle();

    // Reset while a request is outstanding
    pulse(0, 1);
    chk("pre_reset_req", rd_req, 1);
    rst = 1;
    cycle();
    rst = 0;
    chk("post_reset_req", rd_req, 0);
    chk("post_reset_field", field_o, 0);
    chk("post_reset_cnt", underrun_cnt, 0);
    cycle();

    // Disable during REQ: transfer completes, then ticks ignored
    pulse(1, 0);
    pulse(0, 1);
    enable = 0;
    wait_idle();
    cycle();
    for (int i = 0; i < 3; i++) begin pulse(0, 1); cycle(); end
    chk("disabled_no_busy", busy, 0);
    chk("disabled_no_req", rd_req, 0);

    // Random phase
    for (int i = 0; i < 2000; i++) begin
      ack_lat     = $urandom_range(0, 3);
      done_lat    = $urandom_range(0, 6);
      enable      = ($urandom_range(0, 99) < 95);
      field_start = ($urandom_range(0, 99) < 4);
      line_tick   = ($urandom_range(0, 99) < 25);
      rst         = ($urandom_range(0, 999) < 4);
      cycle();
    end
    rst = 0; field_start = 0; line_tick = 0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
